fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and issues single-outstanding requests to a variable-latency instruction memory. Responses go into the IF/ID pipeline register consumed by decode. Hazard-unit stalls (PC_Write) and EX-stage redirects (PCSrc_E) are honoured, with a one-entry hold buffer and stale-response dropping.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and keeps one request outstanding to a
// variable-latency instruction memory. It feeds the IF/ID register, has a
// one-entry hold buffer for stalls, and drops responses made stale by redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        PCSrc_E,
  input  logic [31:0] PC_Target_E,
  output logic [31:0] PC_o,
  output logic        imem_req,
  input  logic        imem_rvalid,
  input  logic [31:0] ins_i,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] instr_d_reg, instr_d_next;
  logic [31:0] pc_d_reg, pc_d_next;
  logic [31:0] pcplus4_d_reg, pcplus4_d_next;
  logic        valid_d_reg, valid_d_next;

  logic        req;
  logic        avail;
  logic [31:0] avail_word;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = {PC_Target_E[31:2], 2'b00};
  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    buf_next   = buf_reg;
    req        = 1'b0;
    avail      = 1'b0;
    avail_word = ins_i;

    unique case (state_reg)
      ISSUE: begin
        req = ~PCSrc_E;
        if (PCSrc_E) pc_next = target;
        else         state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          avail = 1'b1;
          if (PCSrc_E) begin
            pc_next    = target;
            state_next = ISSUE;
          end else if (PC_Write) begin
            pc_next    = pc_plus4;
            state_next = ISSUE;
          end else begin
            buf_next   = ins_i;
            state_next = HOLD;
          end
        end else if (PCSrc_E) begin
          pc_next    = target;
          state_next = DROP;
        end
      end
      HOLD: begin
        avail      = 1'b1;
        avail_word = buf_reg;
        if (PCSrc_E) begin
          buf_next   = NOP_INSTR;
          pc_next    = target;
          state_next = ISSUE;
        end else if (PC_Write) begin
          pc_next    = pc_plus4;
          state_next = ISSUE;
        end
      end
      DROP: begin
        // The outstanding response belongs to the old path; only the PC moves.
        if (PCSrc_E)     pc_next    = target;
        if (imem_rvalid) state_next = ISSUE;
      end
      default: state_next = ISSUE;
    endcase
  end

  always_comb begin
    instr_d_next   = instr_d_reg;
    pc_d_next      = pc_d_reg;
    pcplus4_d_next = pcplus4_d_reg;
    valid_d_next   = valid_d_reg;
    if (PC_Write || PCSrc_E) begin
      if (PCSrc_E || !avail) begin
        valid_d_next = 1'b0;
        instr_d_next = NOP_INSTR;
      end else begin
        valid_d_next   = 1'b1;
        instr_d_next   = avail_word;
        pc_d_next      = pc_reg;
        pcplus4_d_next = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ISSUE;
      pc_reg        <= RESET_PC;
      buf_reg       <= NOP_INSTR;
      instr_d_reg   <= NOP_INSTR;
      pc_d_reg      <= 32'd0;
      pcplus4_d_reg <= 32'd0;
      valid_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      buf_reg       <= buf_next;
      instr_d_reg   <= instr_d_next;
      pc_d_reg      <= pc_d_next;
      pcplus4_d_reg <= pcplus4_d_next;
      valid_d_reg   <= valid_d_next;
    end
  end

  // Gate with rst_n so no request escapes while reset is held.
  assign imem_req  = req & rst_n;
  assign PC_o      = pc_reg;
  assign Instr_D   = instr_d_reg;
  assign PC_D      = pc_d_reg;
  assign PCPlus4_D = pcplus4_d_reg;
  assign Valid_D   = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model of the fetch unit plus a
// latency-programmable instruction memory, driven by directed and random stimulus.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_Write = 1'b0;
  logic        PCSrc_E = 1'b0;
  logic [31:0] PC_Target_E = 32'd0;
  logic [31:0] PC_o;
  logic        imem_req;
  logic        imem_rvalid = 1'b0;
  logic [31:0] ins_i = 32'd0;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .PCSrc_E(PCSrc_E),
    .PC_Target_E(PC_Target_E), .PC_o(PC_o), .imem_req(imem_req),
    .imem_rvalid(imem_rvalid), .ins_i(ins_i), .Instr_D(Instr_D),
    .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: pending = a request is in flight, stale = its answer is unwanted,
  // held = a word is parked waiting for decode to accept it.
  logic [31:0] m_pc, m_buf, m_instr, m_pcd, m_pcp4;
  bit          m_pending, m_stale, m_held, m_valid;
  int          imem_cnt = 0;
  int          lat = 1;

  task automatic model_reset();
    m_pc = 32'd0; m_buf = NOP; m_pending = 0; m_stale = 0; m_held = 0;
    m_valid = 0; m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0;
  endtask

  // rst_ctl: 0 = none, 1 = assert reset between edges, 2 = release at this negedge
  task automatic cycle(input logic pw, input logic ps, input logic [31:0] tgt, input int rst_ctl);
    logic        exp_req;
    logic [31:0] w;
    bit          av;
    @(negedge clk);
    if (rst_ctl == 2) rst_n = 1'b1;
    imem_rvalid = 1'b0;
    ins_i = $urandom;
    if (imem_cnt > 0) begin
      if (imem_cnt == 1) imem_rvalid = 1'b1;
      imem_cnt--;
    end
    PC_Write = pw; PCSrc_E = ps; PC_Target_E = tgt;
    #1;
    if (rst_ctl == 1) begin
      rst_n = 1'b0;
      #1;
      model_reset();
    end
    exp_req = rst_n && !m_pending && !m_held && !ps;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check_eq("PC_o", PC_o, m_pc);
    check_eq("Valid_D", {31'd0, Valid_D}, {31'd0, m_valid});
    check_eq("Instr_D", Instr_D, m_instr);
    check_eq("PC_D", PC_D, m_pcd);
    check_eq("PCPlus4_D", PCPlus4_D, m_pcp4);
    $display("[TB] t=%0t rst_n=%0b pw=%0b ps=%0b rv=%0b req=%0b pc=%h valid=%0b instr=%h pc_d=%h",
             $time, rst_n, pw, ps, imem_rvalid, imem_req, PC_o, Valid_D, Instr_D, PC_D);
    if (rst_n) begin
      av = 0; w = 32'd0;
      if (m_held) begin av = 1; w = m_buf; end
      else if (m_pending && !m_stale && imem_rvalid) begin av = 1; w = ins_i; end
      if (ps || pw) begin
        if (ps || !av) begin
          m_valid = 0; m_instr = NOP;
        end else begin
          m_valid = 1; m_instr = w; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4;
        end
      end
      if (m_held) begin
        if (ps) m_held = 0;
        else if (pw) begin m_held = 0; m_pc = m_pc + 32'd4; end
      end else if (!m_pending) begin
        if (!ps) m_pending = 1;
      end else if (m_stale) begin
        if (imem_rvalid) begin m_pending = 0; m_stale = 0; end
      end else if (imem_rvalid) begin
        m_pending = 0;
        if (!ps && pw) m_pc = m_pc + 32'd4;
        else if (!ps) begin m_held = 1; m_buf = ins_i; end
      end else if (ps) begin
        m_stale = 1;
      end
      if (ps) m_pc = tgt & 32'hFFFF_FFFC;
    end
    if (exp_req) imem_cnt = lat;
  endtask

  initial begin
    model_reset();
    // Hold reset and check reset values, then release.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 2);
    // L=1 straight-line fetch.
    lat = 1;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    // Stall on arrival for 3 cycles, then release.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    // Redirect while waiting (L=2) -> drop stale response.
    lat = 2;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    // Redirect out of HOLD.
    lat = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0200, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    // PC wrap at the top of the address space.
    lat = 2;
    cycle(1, 1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      cycle(($urandom % 4) != 0, ($urandom % 10) == 0,
            (($urandom % 8) == 0) ? 32'hFFFF_FFFD : $urandom, 0);
    end
    // Reset in the middle of a transaction; late response lands in ISSUE.
    lat = 3;
    begin
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        cycle(1, 0, 0, 0);
        if (m_pending && !m_stale && imem_cnt == 3) found = 1;
      end
      check_eq("reach_wait", {31'd0, found}, 32'd1);
    end
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 2);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
